// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address and
// registers the returned instruction into the IF/ID boundary with stall, redirect, halt and fault handling.
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_INST = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] address,
    input  logic [31:0] inst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        id_valid_q, id_valid_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        redirect_s;
    logic [31:0] target_s;

    assign redirect_s = jump | branch_taken;
    assign target_s   = jump ? jump_target : branch_target;

    // Next-state and next-output selection for the fetch sequencer
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_inst_d     = id_inst_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        id_valid_d    = id_valid_q;
        fetch_count_d = fetch_count_q;
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_s) begin
                    // The in-flight fetch is dropped; a misaligned target freezes the PC
                    id_valid_d = 1'b0;
                    if (target_s[1:0] != 2'b00) begin
                        state_d = ST_FAULT;
                    end else begin
                        pc_d = target_s;
                    end
                end else if (!stall) begin
                    id_inst_d     = inst;
                    id_pc_d       = pc_q;
                    id_pc_plus4_d = pc_q + 32'd4;
                    id_valid_d    = 1'b1;
                    fetch_count_d = fetch_count_q + 32'd1;
                    if (inst == HALT_INST) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_HALT: begin
                if (!stall) begin
                    id_valid_d = 1'b0;
                end else begin
                    id_valid_d = id_valid_q;
                end
            end
            ST_FAULT: begin
                id_valid_d = 1'b0;
            end
            default: begin
                state_d    = ST_FAULT;
                id_valid_d = 1'b0;
            end
        endcase
        halted_d = (state_d == ST_HALT);
        fault_d  = (state_d == ST_FAULT);
    end

    // State, PC and IF/ID register bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            id_inst_q     <= 32'd0;
            id_pc_q       <= 32'd0;
            id_pc_plus4_q <= 32'd0;
            id_valid_q    <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_inst_q     <= id_inst_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_valid_q    <= id_valid_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign address     = pc_q;
    assign id_inst     = id_inst_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc_plus4_q;
    assign id_valid    = id_valid_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized control traffic
// compared against a behavioural fetch model; a second instance exercises PC wrap.
module tb_inst_fetch;

    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
    localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, branch_taken, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] addr1, inst1, id_inst1, id_pc1, id_p41, cnt1;
    logic        id_v1, halted1, fault1;
    logic [31:0] addr2, inst2, id_inst2, id_pc2, id_p42, cnt2;
    logic        id_v2, halted2, fault2;

    logic [31:0] seed;
    logic        halt_en;
    logic [31:0] halt_addr;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model state
    int          m_state;
    logic [31:0] m_pc, m_ii, m_ip, m_p4, m_cnt;
    logic        m_v;

    always #5 clk = ~clk;

    assign inst1 = (halt_en && addr1 == halt_addr) ? HALT_W
                 : (((addr1 * 32'h9E37_79B1) ^ seed) & 32'h7FFF_FFFF);
    assign inst2 = ((addr2 * 32'h9E37_79B1) ^ seed) & 32'h7FFF_FFFF;

    inst_fetch dut1 (
        .clk(clk), .rst(rst), .address(addr1), .inst(inst1), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .id_inst(id_inst1), .id_pc(id_pc1), .id_pc_plus4(id_p41), .id_valid(id_v1),
        .halted(halted1), .fault(fault1), .fetch_count(cnt1)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .HALT_INST(32'hFFFF_FFFF)) dut2 (
        .clk(clk), .rst(rst), .address(addr2), .inst(inst2), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .id_inst(id_inst2), .id_pc(id_pc2), .id_pc_plus4(id_p42), .id_valid(id_v2),
        .halted(halted2), .fault(fault2), .fetch_count(cnt2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (halt_en && a == halt_addr) return HALT_W;
        return ((a * 32'h9E37_79B1) ^ seed) & 32'h7FFF_FFFF;
    endfunction

    function automatic logic [31:0] wrap_word(input logic [31:0] a);
        return ((a * 32'h9E37_79B1) ^ seed) & 32'h7FFF_FFFF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("address", addr1, m_pc);
        chk("id_inst", id_inst1, m_ii);
        chk("id_pc", id_pc1, m_ip);
        chk("id_pc_plus4", id_p41, m_p4);
        chk("id_valid", {31'd0, id_v1}, {31'd0, m_v});
        chk("halted", {31'd0, halted1}, {31'd0, m_state == M_HALT});
        chk("fault", {31'd0, fault1}, {31'd0, m_state == M_FAULT});
        chk("fetch_count", cnt1, m_cnt);
    endtask

    // Advance the model by one edge from the rules of the fetch stage
    task automatic model_step();
        logic [31:0] tgt;
        logic [31:0] w;
        w = mem_word(m_pc);
        case (m_state)
            M_BOOT: m_state = M_RUN;
            M_RUN: begin
                if (jump || branch_taken) begin
                    tgt = jump ? jump_target : branch_target;
                    m_v = 1'b0;
                    if (tgt % 4 != 0) m_state = M_FAULT;
                    else m_pc = tgt;
                end else if (!stall) begin
                    m_ii  = w;
                    m_ip  = m_pc;
                    m_p4  = m_pc + 32'd4;
                    m_v   = 1'b1;
                    m_cnt = m_cnt + 32'd1;
                    if (w == HALT_W) m_state = M_HALT;
                    else m_pc = m_pc + 32'd4;
                end
            end
            M_HALT: if (!stall) m_v = 1'b0;
            default: m_v = 1'b0;
        endcase
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic set_ctl(input logic s, input logic b, input logic [31:0] bt,
                           input logic j, input logic [31:0] jt);
        stall = s; branch_taken = b; branch_target = bt; jump = j; jump_target = jt;
    endtask

    task automatic apply_reset();
        set_ctl(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        rst = 1'b1;
        m_state = M_BOOT; m_pc = 32'd0; m_ii = 32'd0; m_ip = 32'd0;
        m_p4 = 32'd0; m_v = 1'b0; m_cnt = 32'd0;
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        seed = $urandom;
        halt_en = 1'b0;
        halt_addr = 32'h0000_000C;
        set_ctl(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Sequential fetch then a 3-cycle stall at address 0x8
        apply_reset();
        repeat (3) cycle();
        chk("seq_addr", addr1, 32'h0000_0008);
        chk("seq_inst0", id_inst1, wrap_word(32'h0000_0004));
        set_ctl(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        repeat (3) begin
            cycle();
            chk("stall_addr", addr1, 32'h0000_0008);
            chk("stall_idpc", id_pc1, 32'h0000_0004);
            chk("stall_valid", {31'd0, id_v1}, 32'd1);
            chk("stall_cnt", cnt1, 32'd2);
        end
        set_ctl(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        cycle();
        chk("resume_idpc", id_pc1, 32'h0000_0008);
        repeat (2) cycle();
        chk("seq_idpc", id_pc1, 32'h0000_0010);
        chk("seq_p4", id_p41, 32'h0000_0014);
        chk("seq_cnt5", cnt1, 32'd5);

        // Jump beats branch and stall in the same cycle
        set_ctl(1'b1, 1'b1, 32'h0000_0020, 1'b1, 32'h0000_0040);
        cycle();
        chk("redir_addr", addr1, 32'h0000_0040);
        chk("redir_bubble", {31'd0, id_v1}, 32'd0);
        set_ctl(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        cycle();
        chk("redir_idpc", id_pc1, 32'h0000_0040);
        chk("redir_inst", id_inst1, wrap_word(32'h0000_0040));
        chk("redir_valid", {31'd0, id_v1}, 32'd1);

        // Randomized aligned redirects and stalls against the model
        for (int i = 0; i < 300; i++) begin
            set_ctl($urandom_range(3) == 0, $urandom_range(9) == 0, $urandom & 32'h0000_0FFC,
                    $urandom_range(19) == 0, $urandom & 32'h0000_0FFC);
            cycle();
        end

        // Halt word at 0xC
        halt_en = 1'b1;
        apply_reset();
        repeat (5) cycle();
        chk("halt_inst", id_inst1, HALT_W);
        chk("halt_deliv_valid", {31'd0, id_v1}, 32'd1);
        chk("halt_idpc", id_pc1, 32'h0000_000C);
        cycle();
        chk("halted", {31'd0, halted1}, 32'd1);
        chk("halt_valid0", {31'd0, id_v1}, 32'd0);
        for (int i = 0; i < 11; i++) begin
            set_ctl($urandom_range(1) == 1, 1'b1, 32'h0000_0020, 1'b1, 32'h0000_0040);
            cycle();
            chk("halt_addr_frozen", addr1, 32'h0000_000C);
        end
        chk("halt_cnt", cnt1, 32'd4);

        // Misaligned branch target
        halt_en = 1'b0;
        apply_reset();
        repeat (2) cycle();
        set_ctl(1'b0, 1'b1, 32'h0000_0022, 1'b0, 32'd0);
        cycle();
        chk("fault_flag", {31'd0, fault1}, 32'd1);
        chk("fault_valid", {31'd0, id_v1}, 32'd0);
        chk("fault_addr", addr1, 32'h0000_0004);
        for (int i = 0; i < 4; i++) begin
            set_ctl($urandom_range(1) == 1, 1'b0, 32'd0, 1'b1, 32'h0000_0100);
            cycle();
        end
        chk("fault_frozen", addr1, 32'h0000_0004);
        apply_reset();
        chk("fault_cleared", {31'd0, fault1}, 32'd0);
        chk("fault_rst_pc", addr1, 32'h0000_0000);

        // PC wrap on the second instance
        chk("wrap_rst_pc", addr2, 32'hFFFF_FFF8);
        cycle();
        chk("wrap_boot_addr", addr2, 32'hFFFF_FFF8);
        chk("wrap_boot_valid", {31'd0, id_v2}, 32'd0);
        cycle();
        chk("wrap_addr_fc", addr2, 32'hFFFF_FFFC);
        chk("wrap_idpc_f8", id_pc2, 32'hFFFF_FFF8);
        cycle();
        chk("wrap_addr_0", addr2, 32'h0000_0000);
        chk("wrap_idpc_fc", id_pc2, 32'hFFFF_FFFC);
        chk("wrap_p4", id_p42, 32'h0000_0000);
        chk("wrap_inst", id_inst2, wrap_word(32'hFFFF_FFFC));
        chk("wrap_cnt", cnt2, 32'd2);

        // Asynchronous reset between clock edges
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_addr", addr2, 32'hFFFF_FFF8);
        chk("async_idpc", id_pc2, 32'd0);
        chk("async_p4", id_p42, 32'd0);
        chk("async_inst", id_inst2, 32'd0);
        chk("async_valid", {31'd0, id_v2}, 32'd0);
        chk("async_cnt", cnt2, 32'd0);
        chk("async_flags", {30'd0, halted2, fault2}, 32'd0);
        chk("async_addr1", addr1, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch stage that drives the instruction memory. Holds the PC, presents it as the fetch address to Inst_mem (combinational read, 32-bit address in, 32-bit instruction out), and registers the returned instruction plus PC into the IF/ID boundary for decode. It handles stall, branch/jump redirect, halt detection and a misaligned-target fault, and counts delivered instructions.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
HALT_INST, 32'hFFFFFFFF, instruction encoding that stops fetch once delivered

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
address  out  32  fetch address to Inst_mem; equals PC combinationally
inst  in  32  instruction returned by Inst_mem in the same cycle
stall  in  1  decode cannot accept; hold PC and IF/ID outputs
branch_taken  in  1  redirect to branch_target
branch_target  in  32  branch destination
jump  in  1  redirect to jump_target; has priority over branch_taken
jump_target  in  32  jump destination
id_inst  out  32  registered instruction to decode
id_pc  out  32  PC of id_inst
id_pc_plus4  out  32  id_pc + 4, modulo 2^32
id_valid  out  1  id_* fields hold a real instruction
halted  out  1  HALT state
fault  out  1  FAULT state (misaligned redirect)
fetch_count  out  32  number of instructions delivered with id_valid=1; wraps

Behaviour:
- Reset (async, any time, including mid-redirect or mid-stall): PC=RESET_PC; id_inst=0, id_pc=0, id_pc_plus4=0, id_valid=0, halted=0, fault=0, fetch_count=0; state=BOOT.
- address = PC at all times; no added latency. The instruction at PC appears on id_inst one clock edge later.
- States: BOOT, RUN, HALT, FAULT.
- BOOT: lasts one cycle after reset release. id_valid stays 0 and PC is held. Next state is RUN.
- RUN: priority per edge is redirect > stall > sequential.
  - Redirect: jump=1 uses jump_target; otherwise branch_taken=1 uses branch_target.
    - If target[1:0] != 0: go to FAULT. PC is held and id_valid<=0.
    - Otherwise: PC<=target and id_valid<=0. This is a one-cycle bubble; the in-flight fetch is discarded.
    - A redirect overrides a simultaneous stall.
  - Stall (no redirect): PC and all id_* outputs hold. fetch_count holds.
  - Sequential: id_inst<=inst, id_pc<=PC, id_pc_plus4<=PC+4, id_valid<=1, fetch_count+=1, PC<=PC+4. PC wraps from 32'hFFFFFFFC to 0.
  - If the latched inst == HALT_INST, the instruction is still delivered with id_valid=1 and state goes to HALT.
- HALT: halted=1, PC frozen. id_valid<=0 on the first unstalled edge; while stall=1, the id_* outputs hold. Redirects are ignored. Exit only by rst.
- FAULT: fault=1, id_valid=0, PC frozen, all inputs ignored. Exit only by rst.
- halted and fault are mutually exclusive. Both are registered and decoded from state.
- Only RUN sequential edges increment fetch_count. It wraps modulo 2^32.

Test Plan:
- Sequential fetch: rst pulse, then memory holds distinct words at 0x0, 0x4, 0x8, 0xC, 0x10 -> address steps 0, 4, 8, C, 10 one per cycle after BOOT. Each id_inst matches the word at id_pc one cycle later, id_pc_plus4=id_pc+4, fetch_count=5 after 5 deliveries.
- Stall: assert stall for 3 cycles while address=0x8 -> address stays 0x8, id_pc stays 0x4, id_valid stays 1, fetch_count unchanged. After release, fetch resumes at 0x8 with no duplicate or skipped delivery.
- Redirect priority: jump=1 (target 0x40) with branch_taken=1 (target 0x20) and stall=1 in the same cycle -> next address=0x40, id_valid=0 for exactly one cycle, then the word at 0x40 is delivered.
- Misaligned target: branch_taken=1, branch_target=0x22 -> fault=1 next edge, id_valid=0, address frozen. Asserting rst afterwards gives PC=RESET_PC and fault=0.
- Halt: word at 0xC is 32'hFFFFFFFF -> it is delivered with id_valid=1, then halted=1, id_valid=0 and address stays 0xC for 10+ cycles. A jump asserted in this period is ignored.
- Wrap and async reset: force RESET_PC=32'hFFFFFFF8 -> addresses FFFFFFF8, FFFFFFFC, 0x0, and id_pc_plus4 for FFFFFFFC is 0. Then assert rst between clock edges -> all outputs go to reset values immediately, without waiting for a clock edge.
